convolutor_mac_unit: RTL and testbench

Multiply-accumulate datapath sitting directly downstream of the convolutor control FSM. Each cycle the FSM asserts its multiply enable, the block multiplies the X and Y samples just read from the synchronous-read memories and accumulates the product into the current output sample. On the term tagged as last, it writes the saturated sum to the Z memory at an auto-incrementing address. The FSM sequences the terms; this block owns the products, sums, Z addresses and Z write strobes.

---
 rtl/convolutor_mac_unit.sv | 114 +++++++++++
 tb/tb_convolutor_mac_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/convolutor_mac_unit.sv
// convolutor_mac_unit
// Two-stage multiply-accumulate datapath fed by the convolutor control FSM.
// Stage 1 registers the X*Y product of each enabled term. Stage 2 accumulates
// the products of one output sample. On the last term it writes the saturated
// sum to the Z memory at an auto-incrementing address.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start_h       synchronous clear of pipeline, address pointer and flags
//   mult_enable_h x_data_i/y_data_i carry a valid term this cycle
//   last_term_h   the current term closes the output sample (qualified by mult_enable_h)
//   x_data_i      X memory read data
//   y_data_i      Y memory read data
//   z_data_o      Z write data (saturated sum), held between writes
//   z_addr_o      Z write address, held between writes
//   z_write_o     single-cycle Z write strobe
//   busy_o        a term is in flight in stage 1 or stage 2
//   sat_o         sticky: some written sample was saturated
module convolutor_mac_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 21,
    parameter int Z_WIDTH     = 16,
    parameter int ZADDR_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_h,
    input  logic                   mult_enable_h,
    input  logic                   last_term_h,
    input  logic [DATA_WIDTH-1:0]  x_data_i,
    input  logic [DATA_WIDTH-1:0]  y_data_i,
    output logic [Z_WIDTH-1:0]     z_data_o,
    output logic [ZADDR_WIDTH-1:0] z_addr_o,
    output logic                   z_write_o,
    output logic                   busy_o,
    output logic                   sat_o
);

    localparam logic [ACC_WIDTH-1:0] Z_MAX = ACC_WIDTH'({Z_WIDTH{1'b1}});

    // Stage 1 state
    logic [2*DATA_WIDTH-1:0] product;
    logic                    p_valid;
    logic                    p_last;

    // Stage 2 state
    logic [ACC_WIDTH-1:0]   acc;
    logic                   first;
    logic [ZADDR_WIDTH-1:0] wr_ptr;

    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   over;

    // The first term of a sample replaces the accumulator instead of adding to it.
    always_comb begin
        acc_next = (first ? '0 : acc) + ACC_WIDTH'(product);
        over     = (acc_next > Z_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else if (start_h) begin
            product <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= mult_enable_h;
            p_last  <= mult_enable_h & last_term_h;
            if (mult_enable_h)
                product <= (2*DATA_WIDTH)'(x_data_i) * (2*DATA_WIDTH)'(y_data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            first     <= 1'b1;
            wr_ptr    <= '0;
            z_data_o  <= '0;
            z_addr_o  <= '0;
            z_write_o <= 1'b0;
            sat_o     <= 1'b0;
        end else if (start_h) begin
            acc       <= '0;
            first     <= 1'b1;
            wr_ptr    <= '0;
            z_data_o  <= '0;
            z_addr_o  <= '0;
            z_write_o <= 1'b0;
            sat_o     <= 1'b0;
        end else begin
            z_write_o <= 1'b0;
            if (p_valid) begin
                acc   <= acc_next;
                first <= p_last;
                if (p_last) begin
                    z_write_o <= 1'b1;
                    z_data_o  <= over ? '1 : acc_next[Z_WIDTH-1:0];
                    z_addr_o  <= wr_ptr;
                    wr_ptr    <= wr_ptr + ZADDR_WIDTH'(1);
                    if (over)
                        sat_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o = p_valid | ~first;

endmodule

// File: tb/tb_convolutor_mac_unit.sv
module tb_convolutor_mac_unit;

    logic       clk;
    logic       rst_n;
    logic       start_h;
    logic       mult_enable_h;
    logic       last_term_h;
    logic [7:0] x_data_i;
    logic [7:0] y_data_i;
    logic [15:0] z_data_o;
    logic [5:0]  z_addr_o;
    logic        z_write_o;
    logic        busy_o;
    logic        sat_o;

    int compared = 0;
    int mismatched = 0;

    convolutor_mac_unit #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (21),
        .Z_WIDTH    (16),
        .ZADDR_WIDTH(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_h      (start_h),
        .mult_enable_h(mult_enable_h),
        .last_term_h  (last_term_h),
        .x_data_i     (x_data_i),
        .y_data_i     (y_data_i),
        .z_data_o     (z_data_o),
        .z_addr_o     (z_addr_o),
        .z_write_o    (z_write_o),
        .busy_o       (busy_o),
        .sat_o        (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input int x, input int y, input logic last);
        mult_enable_h = 1'b1;
        last_term_h   = last;
        x_data_i      = 8'(x);
        y_data_i      = 8'(y);
        tick();
        mult_enable_h = 1'b0;
        last_term_h   = 1'b0;
        x_data_i      = '0;
        y_data_i      = '0;
    endtask

    task automatic start();
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
    endtask

    int strobes;
    int exp_addr;

    initial begin
        rst_n = 1'b0;
        start_h = 1'b0;
        mult_enable_h = 1'b0;
        last_term_h = 1'b0;
        x_data_i = '0;
        y_data_i = '0;

        // Reset state
        #12;
        check("rst_z_data", int'(z_data_o), 0);
        check("rst_z_addr", int'(z_addr_o), 0);
        check("rst_z_write", int'(z_write_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_sat", int'(sat_o), 0);
        rst_n = 1'b1;
        tick();

        // Three-term sample: 6 + 20 + 7 = 33
        start();
        term(2, 3, 1'b0);
        term(4, 5, 1'b0);
        check("busy_mid_sample", int'(busy_o), 1);
        term(1, 7, 1'b1);
        check("no_early_write", int'(z_write_o), 0);
        tick();
        check("s1_write", int'(z_write_o), 1);
        check("s1_data", int'(z_data_o), 33);
        check("s1_addr", int'(z_addr_o), 0);
        check("s1_busy_fall", int'(busy_o), 0);
        tick();
        check("s1_strobe_single", int'(z_write_o), 0);
        check("s1_data_hold", int'(z_data_o), 33);

        // Back-to-back single-term samples
        start();
        check("start_clr_data", int'(z_data_o), 0);
        term(1, 1, 1'b1);
        term(2, 2, 1'b1);
        check("b2b_w0", int'(z_write_o), 1);
        check("b2b_d0", int'(z_data_o), 1);
        check("b2b_a0", int'(z_addr_o), 0);
        tick();
        check("b2b_w1", int'(z_write_o), 1);
        check("b2b_d1", int'(z_data_o), 4);
        check("b2b_a1", int'(z_addr_o), 1);
        tick();
        check("b2b_idle", int'(z_write_o), 0);

        // Saturation: 65025 * 2 = 130050 > 65535
        start();
        term(255, 255, 1'b0);
        term(255, 255, 1'b1);
        tick();
        check("sat_write", int'(z_write_o), 1);
        check("sat_data", int'(z_data_o), 65535);
        check("sat_flag", int'(sat_o), 1);
        tick();
        check("sat_sticky", int'(sat_o), 1);
        start();
        check("sat_clr_start", int'(sat_o), 0);

        // Address wrap over 65 single-term samples
        start();
        strobes = 0;
        exp_addr = 0;
        for (int i = 0; i < 67; i++) begin
            if (i < 65) term(1, 1, 1'b1);
            else tick();
            if (z_write_o) begin
                check("wrap_addr", int'(z_addr_o), exp_addr % 64);
                check("wrap_data", int'(z_data_o), 1);
                exp_addr++;
                strobes++;
            end
        end
        check("wrap_strobes", strobes, 65);
        check("wrap_final_addr", int'(z_addr_o), 0);

        // Gaps and an unqualified last tag: 9 + 2 = 11
        start();
        strobes = 0;
        term(3, 3, 1'b0);
        tick();
        last_term_h = 1'b1;
        tick();
        last_term_h = 1'b0;
        check("gap_no_write_a", int'(z_write_o), 0);
        tick();
        check("gap_no_write_b", int'(z_write_o), 0);
        check("gap_busy", int'(busy_o), 1);
        term(1, 2, 1'b1);
        tick();
        check("gap_write", int'(z_write_o), 1);
        check("gap_data", int'(z_data_o), 11);

        // start_h one cycle after a last term discards the pending write
        start();
        term(9, 9, 1'b0);
        term(5, 5, 1'b1);
        start();
        check("abort_no_write", int'(z_write_o), 0);
        check("abort_addr", int'(z_addr_o), 0);
        check("abort_data", int'(z_data_o), 0);
        check("abort_busy", int'(busy_o), 0);
        tick();
        check("abort_no_write_late", int'(z_write_o), 0);
        term(2, 2, 1'b1);
        tick();
        check("abort_next_write", int'(z_write_o), 1);
        check("abort_next_addr", int'(z_addr_o), 0);
        check("abort_next_data", int'(z_data_o), 4);

        // Asynchronous reset mid-sample
        term(3, 3, 1'b0);
        term(3, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", int'(z_data_o), 0);
        check("arst_addr", int'(z_addr_o), 0);
        check("arst_write", int'(z_write_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_sat", int'(sat_o), 0);
        tick();
        rst_n = 1'b1;
        term(6, 7, 1'b1);
        tick();
        check("post_rst_write", int'(z_write_o), 1);
        check("post_rst_data", int'(z_data_o), 42);
        check("post_rst_addr", int'(z_addr_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
